// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x DATA_WIDTH register file with one write port and two
// registered read ports.
//  - Write when WRITE=1 and READ=0; read when READ=1 and WRITE=0.
//  - READ=1 with WRITE=1 is illegal: the edge is ignored and the storage and
//    outputs hold. READ=0 with WRITE=0 also holds.
//  - Asynchronous active-low reset clears the storage and both outputs.
// Optional feature macro: REG_FILE_R0_ZERO_EN
//  - Register 0 is hard-wired to zero. Writes to it are dropped, and reads of
//    address 0 return 0.
module reg_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_r1;
    logic [DATA_WIDTH-1:0] r_data_r2;

    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_wr_addr_ok;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // The illegal READ+WRITE combination must enable neither operation.
    assign w_rd_en = READ & ~WRITE;
    assign w_wr_en = WRITE & ~READ;

`ifdef REG_FILE_R0_ZERO_EN
    // Register 0 is read-only zero, so writes to it are dropped.
    assign w_wr_addr_ok = (ADDR_W != '0);
    assign w_rd1        = (ADDR_R1 == '0) ? '0 : r_mem[ADDR_R1];
    assign w_rd2        = (ADDR_R2 == '0) ? '0 : r_mem[ADDR_R2];
`else
    assign w_wr_addr_ok = 1'b1;
    assign w_rd1        = r_mem[ADDR_R1];
    assign w_rd2        = r_mem[ADDR_R2];
`endif

    // Storage update: a single write port, cleared asynchronously on reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en && w_wr_addr_ok) begin
            r_mem[ADDR_W] <= DATA_W;
        end
    end

    // Read data is registered only on a legal read edge. Otherwise it holds,
    // so the outputs never follow the address inputs combinationally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
        end else if (w_rd_en) begin
            r_data_r1 <= w_rd1;
            r_data_r2 <= w_rd2;
        end
    end

    assign DATA_R1 = r_data_r1;
    assign DATA_R2 = r_data_r2;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32. The stimulus process updates an
// array-based reference model and pushes the expected outputs for each clock
// edge. The monitor pops an entry after every edge and compares it.
module tb_reg_file_32x32;

    logic        CLK;
    logic        RST;
    logic        READ;
    logic        WRITE;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    reg_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .DATA_R1(DATA_R1), .DATA_R2(DATA_R2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          step_id = 0;

    // Reference model: register contents plus the last values read out.
    logic [31:0] m_mem [32];
    logic [31:0] m_out1;
    logic [31:0] m_out2;

    function automatic void check(input string name, input int id,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, id, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_out1 = 32'd0;
        m_out2 = 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input int a);
`ifdef REG_FILE_R0_ZERO_EN
        if (a == 0) return 32'd0;
`endif
        return m_mem[a];
    endfunction

    // Drive one operation at a falling edge. Update the model, queue the
    // expected outputs for the next rising edge, then wait for the next
    // falling edge.
    task automatic step(input bit rd, input bit wr, input int a1, input int a2,
                        input int aw, input logic [31:0] dw);
        exp_t e;
        READ    = rd;
        WRITE   = wr;
        ADDR_R1 = a1[4:0];
        ADDR_R2 = a2[4:0];
        ADDR_W  = aw[4:0];
        DATA_W  = dw;
        if (rd && !wr) begin
            m_out1 = model_read(a1);
            m_out2 = model_read(a2);
        end else if (wr && !rd) begin
`ifdef REG_FILE_R0_ZERO_EN
            if (aw != 0) m_mem[aw] = dw;
`else
            m_mem[aw] = dw;
`endif
        end
        e.d1 = m_out1;
        e.d2 = m_out2;
        e.id = step_id++;
        sb.push_back(e);
        @(negedge CLK);
    endtask

    // Monitor: one expected entry for each rising edge taken out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data_r1", e.id, DATA_R1, e.d1);
                check("data_r2", e.id, DATA_R2, e.d2);
            end
        end
    end

    initial begin
        int          budget;
        logic [31:0] v;
        RST = 1'b0; READ = 1'b0; WRITE = 1'b0;
        ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;
        model_reset();
        #2;
        check("reset_r1", -1, DATA_R1, 32'd0);
        check("reset_r2", -1, DATA_R2, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // After reset, every address reads back as zero.
        for (int i = 0; i < 32; i++) step(1, 0, i, i, 0, 32'd0);

        // Write sweep: address i receives the value i.
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0, i, 32'(i));
        for (int i = 0; i < 32; i++) step(1, 0, i, i, 0, 32'd0);

        // Illegal READ+WRITE sweep: outputs must hold 31 and storage must not change.
        for (int i = 0; i < 32; i++) step(1, 1, i, i, i, 32'hA5A5_0000 | 32'(i));
        for (int i = 0; i < 32; i++) step(1, 0, i, 31 - i, 0, 32'd0);

        // Independent read ports on the same edge.
        step(1, 0, 5, 9, 0, 32'd0);
        step(0, 0, 3, 4, 0, 32'd0);

        // Randomized mix of reads, writes, illegal edges and idle edges.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            v  = $urandom;
            if (op < 4)       step(1, 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, v);
            else if (op < 8)  step(0, 1, 0, 0, int'($urandom_range(0, 31)), v);
            else if (op == 8) step(1, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                                   int'($urandom_range(0, 31)), v);
            else              step(0, 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, v);
        end

        // Write to address 0. With the zero-register option the read-back must be 0.
        step(0, 1, 0, 0, 0, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 0, 32'd0);

        // Reset asserted between edges while the outputs show 31.
        step(0, 1, 0, 0, 31, 32'd31);
        step(1, 0, 31, 31, 0, 32'd0);
        #2;
        RST = 1'b0;
        READ = 1'b1; WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'hFFFF_FFFF;
        #1;
        check("async_rst_r1", -2, DATA_R1, 32'd0);
        check("async_rst_r2", -2, DATA_R2, 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        step(1, 0, 7, 31, 0, 32'd0);
        step(0, 1, 0, 0, 12, 32'h1234_5678);
        step(1, 0, 12, 12, 0, 32'd0);

        // Drain the scoreboard within a bounded number of cycles.
        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
